booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
- Shares one fixed-latency pipelined 32x32 Booth multiplier between NREQ requesters.
- Round-robin arbitration; issues at most one operation per cycle.
- Carries the requester ID alongside the multiplier pipeline and buffers results in a show-ahead response FIFO.
- A credit counter guarantees the FIFO never overflows, because the multiplier pipeline itself cannot stall.

Parameters:
- NREQ, 4: number of requesters.
- IDW, 2: requester ID width; must equal clog2(NREQ).
- LAT, 2: multiplier latency in cycles, from operands presented to product valid.
- FIFO_DEPTH, 4: response FIFO entries; also the maximum number of outstanding operations.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*32  signed multiplier operands; requester i uses bits [32i+31:32i].
- req_b  in  NREQ*32  signed multiplicand operands; same packing as req_a.
- mul_valid_o  out  1  operands on mul_a_o/mul_b_o are a real issue this cycle.
- mul_a_o  out  32  multiplier operand to the Booth pipeline.
- mul_b_o  out  32  multiplicand operand to the Booth pipeline.
- mul_p_i  in  64  signed product from the Booth pipeline, LAT cycles after issue.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts the head.
- rsp_id  out  IDW  requester ID of the head entry.
- rsp_data  out  64  product of the head entry.

Behaviour:
- Reset (async, active-low):
  - Clears the RR pointer to 0, the tag shift register (valid and ID), the FIFO pointers and count, and the outstanding counter.
  - Outputs: rsp_valid=0, rsp_id=0, rsp_data=0, mul_valid_o=0, req_ready=0.
  - Products in flight at reset are discarded; late mul_p_i values are ignored because their tag valid is cleared.
- Issue condition: can_issue = (outstanding < FIFO_DEPTH) && (|req_valid).
- Arbitration (combinational):
  - Grant the first asserted req_valid searching from index ptr upward, wrapping modulo NREQ.
  - req_ready = onehot(grant) when can_issue, else 0.
  - mul_a_o/mul_b_o = operands of the granted requester; mul_valid_o = can_issue.
  - When not issuing, mul_a_o and mul_b_o are 0.
- RR pointer: on issue, ptr <= (grant+1) mod NREQ; otherwise it holds. Wrap: grant NREQ-1 gives ptr 0.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}, advancing every cycle.
  - Stage 0 loads {can_issue, grant}.
  - Stage LAT-1 output is aligned with mul_p_i. When its valid is set, push {id, mul_p_i} into the FIFO that cycle.
- Response FIFO:
  - Depth FIFO_DEPTH, registered storage, show-ahead: rsp_valid = (count != 0), and rsp_id/rsp_data show the head.
  - Pop when rsp_valid && rsp_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Push while full cannot happen by construction; the bench asserts this never occurs.
  - Empty with a push: the data appears on rsp_* the next cycle, with no fall-through.
- Outstanding counter (0..FIFO_DEPTH):
  - +1 on issue, -1 on pop, unchanged when both occur in the same cycle.
  - Counts both in-flight and buffered entries.
  - Issue is blocked when the counter equals FIFO_DEPTH.
  - A pop in the same cycle does not unblock issue that cycle; the credit frees next cycle.
- Latency: issue at cycle t gives rsp_valid at t+LAT+1 when the FIFO is empty.
- Ordering: responses return in issue order; there is no reordering.
- Requester rules:
  - A requester holds req_valid and its operands stable until req_ready is seen.
  - The arbiter does not require this for correctness.

Test Plan:
- Single op: requester 2 sends a=-3, b=7, rsp_ready=1. Expect req_ready=4'b0100 the same cycle and mul_valid_o=1. Model the pipeline returning -21. Expect rsp_valid at issue+3 with rsp_id=2 and rsp_data=64'hFFFF_FFFF_FFFF_FFEB.
- Round-robin fairness: all four req_valid held high for 8 cycles with rsp_ready=1. Expect grant order 0,1,2,3,0,1,2,3 and responses tagged in the same order.
- Back-pressure: rsp_ready=0 with continuous requests. Expect exactly 4 issues, then req_ready=0 and mul_valid_o=0. Raise rsp_ready. Expect one new issue per pop, with credit freed one cycle after each pop.
- Simultaneous push and pop: steady state with FIFO count 2, one issue and one pop per cycle. Expect count stays at 2 and outstanding stays constant.
- Reset mid-operation: assert rst_n=0 with 3 ops in flight. Expect rsp_valid=0 immediately and no responses after release. The first new op after release is granted to requester 0 (ptr=0).
- Operand corners: a=32'h8000_0000, b=-1 on requester 3. Expect the product passes through unchanged with ID 3, and ptr wraps to 0.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined Booth multiplier.
// Requester IDs ride a tag pipeline alongside the products into a credit-protected show-ahead FIFO.
module booth_mul_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 mul_valid_o,
  output logic [31:0]          mul_a_o,
  output logic [31:0]          mul_b_o,
  input  logic [63:0]          mul_p_i,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_data
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  fifo_cnt;
  logic           can_issue;
  logic           push;
  logic           pop;
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];
  logic [IDW-1:0] mem_id [FIFO_DEPTH];
  logic [63:0]    mem_data [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [31:0]    a_arr [NREQ];
  logic [31:0]    b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  // Scan downward so the last hit, i.e. the nearest index at or above ptr, wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) grant = idx;
    end
  end

  assign can_issue   = (outstanding < CW'(FIFO_DEPTH)) && (|req_valid);
  assign req_ready   = can_issue ? (NREQ'(1) << grant) : '0;
  assign mul_valid_o = can_issue;
  assign mul_a_o     = can_issue ? a_arr[grant] : '0;
  assign mul_b_o     = can_issue ? b_arr[grant] : '0;

  assign push      = tag_v[LAT-1];
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      tag_v <= '0;
      for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
    end else begin
      if (can_issue) ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
      tag_v[0]  <= can_issue;
      tag_id[0] <= grant;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= tag_id[LAT-1];
      mem_data[wr_ptr] <= mul_p_i;
    end
  end

  // Credits cover in-flight and buffered results, so a push never meets a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (can_issue && !pop)      outstanding <= outstanding + 1'b1;
      else if (!can_issue && pop) outstanding <= outstanding - 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural LAT-stage multiplier model.
module tb_booth_mul_arbiter;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic          mul_valid_o;
  logic [31:0]   mul_a_o;
  logic [31:0]   mul_b_o;
  logic [63:0]   mul_p_i;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_data;

  logic [31:0]   a_op [4];
  logic [31:0]   b_op [4];
  logic [63:0]   pipe [LAT];

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  int checks = 0;
  int errors = 0;

  booth_mul_arbiter #(.NREQ(4), .IDW(2), .LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_p_i(mul_p_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
    req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};
  end

  // External Booth pipeline stand-in: signed product LAT cycles after issue.
  always @(posedge clk) begin
    pipe[0] <= 64'(longint'($signed(mul_a_o)) * longint'($signed(mul_b_o)));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p_i = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d data %h expected none at %0t", rsp_id, rsp_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_data", rsp_data, mon_e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && dut.push && dut.fifo_cnt == 3'd4) begin
      errors++;
      $display("FAIL fifo_overflow: got push with count %0d expected count below 4", dut.fifo_cnt);
    end
  end

  // One cycle: inputs already driven; checks at negedge, returns at next posedge + 1.
  task automatic tick(input logic [3:0] exp_ready, input int exp_out = -1,
                      input int exp_cnt = -1, input int exp_rv = -1);
    int   idx;
    rsp_t e;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("mul_valid", 64'(mul_valid_o), 64'(|exp_ready));
    if (exp_ready != 4'b0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (exp_ready[i]) idx = i;
      chk("mul_a", 64'(mul_a_o), 64'(a_op[idx]));
      chk("mul_b", 64'(mul_b_o), 64'(b_op[idx]));
      e.id   = 2'(idx);
      e.data = 64'(longint'($signed(a_op[idx])) * longint'($signed(b_op[idx])));
      exp_q.push_back(e);
    end else begin
      chk("mul_a_idle", 64'(mul_a_o), 64'd0);
      chk("mul_b_idle", 64'(mul_b_o), 64'd0);
    end
    if (exp_out >= 0) chk("outstanding", 64'(dut.outstanding), 64'(exp_out));
    if (exp_cnt >= 0) chk("fifo_cnt", 64'(dut.fifo_cnt), 64'(exp_cnt));
    if (exp_rv >= 0)  chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(4'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    tick(4'b0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin a_op[i] = '0; b_op[i] = '0; end
    #12;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_mul_valid", 64'(mul_valid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin with all requesters active; steady state holds 3 credits, 1 buffered entry.
    a_op[0] = 32'd5;      b_op[0] = 32'd7;
    a_op[1] = -32'sd6;    b_op[1] = 32'd3;
    a_op[2] = 32'd100000; b_op[2] = -32'sd200000;
    a_op[3] = -32'sd1;    b_op[3] = -32'sd1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= 3) tick(4'(1 << (k % 4)), 3, 1);
      else        tick(4'(1 << (k % 4)));
    end
    drain();

    // Single op on requester 2: -3 * 7 = -21 = 64'hFFFF_FFFF_FFFF_FFEB, valid at issue+3.
    a_op[2] = -32'sd3; b_op[2] = 32'd7;
    req_valid = 4'b0100;
    tick(4'b0100);
    req_valid = 4'b0;
    tick(4'b0, -1, -1, 0);
    tick(4'b0, -1, -1, 0);
    tick(4'b0, -1, -1, 1);
    drain();

    // Corner operands on requester 3: 0x8000_0000 * -1 = 64'h0000_0000_8000_0000; ptr wraps to 0.
    a_op[3] = 32'h8000_0000; b_op[3] = 32'hFFFF_FFFF;
    req_valid = 4'b1000;
    tick(4'b1000);
    req_valid = 4'b1111;
    tick(4'b0001);
    drain();

    // Back-pressure: ptr=1, four issues then stalled; credit returns one cycle after first pop.
    for (int i = 0; i < 4; i++) b_op[i] = 32'(i + 11);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    tick(4'b0010); tick(4'b0100); tick(4'b1000); tick(4'b0001);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) tick(4'b0, 4, 4, 1);
      else        tick(4'b0, 4);
    end
    rsp_ready = 1'b1;
    tick(4'b0, 4, 4, 1);
    tick(4'b0010, 3);
    tick(4'b0100, 3);
    tick(4'b1000, 3);
    tick(4'b0001, 3);
    drain();

    // Reset with three ops outstanding (ptr left at 2), then verify ptr restarts at 0.
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    tick(4'b0010); tick(4'b0100); tick(4'b0010);
    req_valid = 4'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", rsp_data, 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick(4'b0, 0, 0, 0);
    req_valid = 4'b0110;
    tick(4'b0010);
    req_valid = 4'b1111;
    tick(4'b0100);
    drain();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    tick(4'b0001);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
